// File: rtl/sram_upload_reader.sv
// sram_upload_reader
// Upload-side reader for the board's 8-bit asynchronous SRAM. It keeps one byte
// prefetched on ioctl_din for the data_io upload path. It shares the SRAM with
// the video fetch path through a req/gnt arbiter that lives in the top level.
// Optional feature: define UPLOAD_CHECKSUM_EN to add a 16-bit running checksum
// output over every byte the host consumes.
module sram_upload_reader #(
  parameter int unsigned ADDR_W      = 32'd19,
  parameter int unsigned WAIT_STATES = 32'd1,
  parameter int unsigned BASE_ADDR   = 32'd0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              din_valid,
  output logic              sram_req,
  input  logic              sram_gnt,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_oe_n,
  input  logic [7:0]        sram_dq,
  output logic              overrun
`ifdef UPLOAD_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_VALID  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_L = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ONE_L  = ADDR_W'(32'd1);
  localparam logic [2:0]        WAIT_L = 3'(WAIT_STATES);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                upload_d_r;
  logic [2:0]          wait_cnt_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic                refetch_r;
  logic                start_s;
  logic                miss_s;
  logic                accept_s;
  logic                latch_s;
  logic [7:0]          din_nxt_s;
  logic                dv_nxt_s;
  logic                req_nxt_s;
  logic                oe_n_nxt_s;
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic                unused_s;

  // Only the low ADDR_W bits of the host address select an SRAM byte.
  assign unused_s = ^ioctl_addr;

  // A fresh upload begins on every rising edge of ioctl_upload.
  assign start_s  = ioctl_upload & ~upload_d_r;
  // The host consumed a byte that was never presented: this is an overrun.
  assign miss_s   = ioctl_upload & ~start_s & ioctl_rd & ~din_valid &
                    ((state_r == ST_REQ) | (state_r == ST_WAIT));
  // The host consumed the byte currently presented on ioctl_din.
  assign accept_s = ioctl_upload & ~start_s & ioctl_rd & din_valid;
  // The bus has just been granted and the fetch address is placed on it.
  assign latch_s  = (state_r == ST_REQ) & (state_nxt_s == ST_WAIT);

  // State register and upload edge detector.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      upload_d_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      upload_d_r <= ioctl_upload;
    end
  end

  // Next-state logic. An abort has priority over everything, then a fresh start.
  always_comb begin
    state_nxt_s = state_r;
    if (!ioctl_upload) begin
      state_nxt_s = ST_IDLE;
    end else if (start_s) begin
      state_nxt_s = ST_REQ;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_REQ: begin
          if (sram_gnt) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          // Losing the bus restarts the fetch. A stale address (the host
          // advanced mid-fetch) finishes its bus cycle and then refetches.
          if (!sram_gnt) begin
            state_nxt_s = ST_REQ;
          end else if (wait_cnt_r == 3'd0) begin
            if (refetch_r || ioctl_rd) begin
              state_nxt_s = ST_REQ;
            end else begin
              state_nxt_s = ST_SAMPLE;
            end
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_SAMPLE, ST_VALID: begin
          if (ioctl_rd) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_VALID;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    dv_nxt_s   = 1'b0;
    req_nxt_s  = 1'b0;
    oe_n_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_REQ: begin
        req_nxt_s = 1'b1;
      end
      ST_WAIT: begin
        req_nxt_s  = 1'b1;
        oe_n_nxt_s = 1'b0;
      end
      ST_SAMPLE, ST_VALID: begin
        dv_nxt_s = 1'b1;
      end
      default: begin
        dv_nxt_s = 1'b0;
      end
    endcase
    if (latch_s) begin
      addr_nxt_s = rd_addr_r;
    end else begin
      addr_nxt_s = sram_addr;
    end
    // sram_dq is only captured on the last granted WAIT cycle.
    if ((state_r == ST_WAIT) && (state_nxt_s == ST_SAMPLE)) begin
      din_nxt_s = sram_dq;
    end else begin
      din_nxt_s = ioctl_din;
    end
  end

  // Output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_din <= 8'd0;
      din_valid <= 1'b0;
      sram_req  <= 1'b0;
      sram_oe_n <= 1'b1;
      sram_addr <= '0;
    end else begin
      ioctl_din <= din_nxt_s;
      din_valid <= dv_nxt_s;
      sram_req  <= req_nxt_s;
      sram_oe_n <= oe_n_nxt_s;
      sram_addr <= addr_nxt_s;
    end
  end

  // Wait-state counter: loaded on grant, counts down while the address settles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= 3'd0;
    end else if (latch_s) begin
      wait_cnt_r <= WAIT_L;
    end else if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
      wait_cnt_r <= wait_cnt_r - 3'd1;
    end else begin
      wait_cnt_r <= 3'd0;
    end
  end

  // Remember that the address on the bus went stale during this fetch.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      refetch_r <= 1'b0;
    end else if (latch_s) begin
      refetch_r <= ioctl_rd;
    end else if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
      refetch_r <= refetch_r | ioctl_rd;
    end else begin
      refetch_r <= 1'b0;
    end
  end

  // Next-fetch address: latched at upload start, advanced on every host read.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_r <= '0;
    end else if (start_s) begin
      rd_addr_r <= BASE_L + ioctl_addr[ADDR_W-1:0];
    end else if (accept_s || miss_s) begin
      rd_addr_r <= rd_addr_r + ONE_L;
    end else begin
      rd_addr_r <= rd_addr_r;
    end
  end

  // Sticky overrun flag, cleared at the start of each upload.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (start_s) begin
      overrun <= 1'b0;
    end else if (miss_s) begin
      overrun <= 1'b1;
    end else begin
      overrun <= overrun;
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  // Running sum of delivered bytes; it holds after the upload ends.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 16'd0;
    end else if (start_s) begin
      checksum <= 16'd0;
    end else if (accept_s) begin
      checksum <= checksum + {8'd0, ioctl_din};
    end else begin
      checksum <= checksum;
    end
  end
`endif

endmodule

// File: doc/sram_upload_reader.md
Name: sram_upload_reader

Overview:
- Read-side counterpart of the download-to-SRAM writer in the menu core: services data_io upload by fetching bytes from the board's 8-bit asynchronous SRAM and presenting them on ioctl_din.
- Keeps exactly one byte prefetched so the SPI side never waits.
- Shares the SRAM with the video fetch path through a req/gnt arbiter in the top level.

Parameters:
- ADDR_W, 19, SRAM address width.
- WAIT_STATES, 1, extra clk_sys cycles to hold the address before sampling sram_dq (0..7).
- BASE_ADDR, 0, SRAM address that corresponds to ioctl_addr 0.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  high while data_io runs an upload.
- ioctl_addr  in  25  byte address the host reads next.
- ioctl_rd  in  1  one-cycle pulse: host consumed ioctl_din, advance to next byte.
- ioctl_din  out  8  byte at the current address.
- din_valid  out  1  ioctl_din holds the byte for the current address.
- sram_req  out  1  request for the SRAM bus.
- sram_gnt  in  1  arbiter grant; bus is ours while high.
- sram_addr  out  ADDR_W  SRAM address.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_dq  in  8  SRAM read data.
- overrun  out  1  sticky error flag: ioctl_rd arrived while din_valid was low.

Behaviour:
- Reset values: ioctl_din=0, din_valid=0, sram_req=0, sram_addr=0, sram_oe_n=1, overrun=0, state=IDLE, wait counter=0.
- Reset is asynchronous and may assert mid-fetch. All outputs return to their reset values immediately. No grant is held after reset.
- Internal next-fetch address rd_addr (ADDR_W bits) = BASE_ADDR + ioctl_addr[ADDR_W-1:0], truncated modulo 2^ADDR_W (wraps around).
- IDLE:
  - On a rising edge of ioctl_upload: latch rd_addr from ioctl_addr, clear overrun, go to REQ.
  - With ioctl_upload low: din_valid=0.
- REQ: sram_req=1. When sram_gnt=1, drive sram_addr=rd_addr and sram_oe_n=0, load wait counter=WAIT_STATES, go to WAIT.
- WAIT: hold address and oe. Decrement the counter. At 0, go to SAMPLE. With WAIT_STATES=0, WAIT lasts exactly 1 cycle.
- SAMPLE:
  - Capture ioctl_din<=sram_dq. Set din_valid=1. Release the bus: sram_req=0, sram_oe_n=1.
  - Go to VALID.
  - Fetch latency from the REQ cycle with gnt=1 to din_valid=1 is WAIT_STATES+2 cycles.
- VALID:
  - On ioctl_rd: din_valid<=0, rd_addr<=rd_addr+1, go to REQ.
- Losing grant:
  - If sram_gnt drops during WAIT: restart the fetch in REQ. Data must not be sampled from a bus we no longer own.
  - sram_req stays high across the restart.
- ioctl_rd while din_valid=0 (REQ/WAIT/SAMPLE): set overrun=1 and still advance rd_addr by one. The fetch in flight completes for the old address, then an immediate refetch occurs for the new address. The byte is never silently duplicated.
- ioctl_upload falling (any state): abort to IDLE, sram_req=0, sram_oe_n=1, din_valid=0. ioctl_din keeps its last value.
- ioctl_upload falling and ioctl_rd on the same cycle: the abort wins.
- ioctl_upload rising while a fetch is in progress (only possible after a one-cycle low glitch): treated as a fresh start.
- sram_addr is only meaningful while sram_req=1 and sram_gnt=1. It holds its value otherwise.

Optional Feature:
- Macro UPLOAD_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [15:0]: a 16-bit running sum (mod 2^16) of every byte delivered. A byte counts as delivered when ioctl_rd is accepted in VALID.
  - Cleared on reset and on each ioctl_upload rising edge.
  - Holds its value after the upload ends so firmware can read it.
  - Bytes consumed under overrun are not added.
- When undefined: no checksum port, no logic, behaviour otherwise identical.

Test Plan:
- Preload SRAM[0..3]=11,22,33,44, BASE_ADDR=0, WAIT_STATES=1, gnt tied high. Raise upload with ioctl_addr=0 and pulse ioctl_rd whenever din_valid=1. Required: ioctl_din sequence 11,22,33,44, overrun=0, din_valid rises 3 cycles after each request.
- Hold gnt low for 10 cycles after upload starts. Required: sram_req=1 throughout, sram_oe_n=1, din_valid=0; the first byte appears WAIT_STATES+2 cycles after gnt rises.
- Drop gnt for 1 cycle in WAIT. Required: the fetch restarts and the correct byte is still delivered; sram_dq is never captured without grant.
- Pulse ioctl_rd while in REQ. Required: overrun=1, and the next delivered byte is from address+1 relative to the byte in flight.
- BASE_ADDR=0x7FFFF, ioctl_addr=1. Required: the first fetch uses sram_addr=0x00000 (wrap).
- Assert reset_n=0 mid-WAIT. Required: all outputs return to reset values asynchronously. With UPLOAD_CHECKSUM_EN, bytes 0xFF,0x02 give checksum=0x0101, cleared on the next upload start.
